// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single-port data RAM between the CPU load/store
// unit (requester C) and the port-copy DMA engine (requester D). Every access
// runs IDLE -> ACCESS -> RESP, so the RAM sees exactly one strobe per access.
// Addresses outside [MEM_LO, MEM_HI] get an error response and never reach
// the RAM. C has priority; D is guaranteed a grant after CPU_BURST
// consecutive C grants while it was waiting.
module dram_arbiter #(
   parameter int unsigned PORT_EXPONENT = 3,
   parameter int unsigned MEM_HI        = 2000,
   parameter int unsigned CPU_BURST     = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        c_valid,
   output logic        c_ready,
   input  logic        c_we,
   input  logic [15:0] c_addr,
   input  logic [15:0] c_wdata,
   output logic        c_rsp_valid,
   output logic        c_rsp_err,
   output logic [15:0] c_rdata,
   input  logic        d_valid,
   output logic        d_ready,
   input  logic        d_we,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_rsp_valid,
   output logic        d_rsp_err,
   output logic [15:0] d_rdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_d_in,
   input  logic [15:0] mem_d_out,
   output logic        busy
);

   localparam logic [15:0] LP_MEM_LO = 16'(2 * (2 ** PORT_EXPONENT));
   localparam logic [15:0] LP_MEM_HI = 16'(MEM_HI);
   localparam logic [3:0]  LP_BURST  = 4'(CPU_BURST);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t      r_state;
   logic        r_owner_d;
   logic        r_we;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;
   logic [15:0] r_rdata;
   logic        r_err;
   logic [3:0]  r_burst_cnt;

   logic        w_idle;
   logic        w_access;
   logic        w_resp;
   logic        w_grant_c;
   logic        w_grant_d;
   logic        w_sel_we;
   logic [15:0] w_sel_addr;
   logic [15:0] w_sel_wdata;
   logic        w_addr_err;
   logic        w_mem_read;
   logic        w_mem_write;

   assign w_idle   = (r_state == S_IDLE);
   assign w_access = (r_state == S_ACCESS);
   assign w_resp   = (r_state == S_RESP);

   // D wins only when C is absent or C has used up its burst allowance
   assign w_grant_d = w_idle && d_valid && (!c_valid || (r_burst_cnt == LP_BURST));
   assign w_grant_c = w_idle && c_valid && !w_grant_d;

   assign w_sel_we    = w_grant_d ? d_we    : c_we;
   assign w_sel_addr  = w_grant_d ? d_addr  : c_addr;
   assign w_sel_wdata = w_grant_d ? d_wdata : c_wdata;
   assign w_addr_err  = (w_sel_addr < LP_MEM_LO) || (w_sel_addr > LP_MEM_HI);

   // Strobes are decoded from the state register, so an async reset drops them at once
   assign w_mem_read  = w_access && !r_we && !r_err;
   assign w_mem_write = w_access &&  r_we && !r_err;

   // Access sequencer: latch the winner in IDLE, strobe the RAM in ACCESS, respond in RESP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_owner_d   <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
         r_burst_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_c || w_grant_d) begin
                  r_owner_d <= w_grant_d;
                  r_we      <= w_sel_we;
                  r_addr    <= w_sel_addr;
                  r_wdata   <= w_sel_wdata;
                  r_err     <= w_addr_err;
                  // Count only C grants that made a waiting D stand aside
                  if (w_grant_c && d_valid) begin
                     r_burst_cnt <= r_burst_cnt + 4'd1;
                  end else begin
                     r_burst_cnt <= '0;
                  end
                  r_state <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               r_rdata <= w_mem_read ? mem_d_out : '0;
               r_state <= S_RESP;
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign c_ready = w_grant_c;
   assign d_ready = w_grant_d;

   assign mem_read  = w_mem_read;
   assign mem_write = w_mem_write;
   assign mem_addr  = w_access ? r_addr  : '0;
   assign mem_d_in  = w_access ? r_wdata : '0;

   assign c_rsp_valid = w_resp && !r_owner_d;
   assign d_rsp_valid = w_resp &&  r_owner_d;
   assign c_rsp_err   = c_rsp_valid && r_err;
   assign d_rsp_err   = d_rsp_valid && r_err;
   assign c_rdata     = c_rsp_valid ? r_rdata : '0;
   assign d_rdata     = d_rsp_valid ? r_rdata : '0;

   assign busy = !w_idle;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: scoreboard bench for dram_arbiter. Grants are predicted
// from the arbitration rules, each accepted request pushes its expected
// response, and a negedge monitor pops and compares responses.
module tb_dram_arbiter;

   localparam int unsigned PE  = 3;
   localparam int unsigned MHI = 2000;
   localparam int unsigned CB  = 4;
   localparam int unsigned MLO = 2 * (2 ** PE);

   logic        clk;
   logic        rst_n;
   logic        c_valid, c_ready, c_we, c_rsp_valid, c_rsp_err;
   logic [15:0] c_addr, c_wdata, c_rdata;
   logic        d_valid, d_ready, d_we, d_rsp_valid, d_rsp_err;
   logic [15:0] d_addr, d_wdata, d_rdata;
   logic        mem_read, mem_write, busy;
   logic [15:0] mem_addr, mem_d_in, mem_d_out;

   dram_arbiter #(.PORT_EXPONENT(PE), .MEM_HI(MHI), .CPU_BURST(CB)) dut (
      .clk(clk), .rst_n(rst_n),
      .c_valid(c_valid), .c_ready(c_ready), .c_we(c_we), .c_addr(c_addr),
      .c_wdata(c_wdata), .c_rsp_valid(c_rsp_valid), .c_rsp_err(c_rsp_err),
      .c_rdata(c_rdata),
      .d_valid(d_valid), .d_ready(d_ready), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid), .d_rsp_err(d_rsp_err),
      .d_rdata(d_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_d_in(mem_d_in), .mem_d_out(mem_d_out), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM attached to the arbiter: combinational read, write on negedge
   logic [15:0] dram [0:2047] = '{default: '0};
   always @(negedge clk) begin
      if (mem_write) dram[mem_addr[10:0]] <= mem_d_in;
   end
   assign mem_d_out = dram[mem_addr[10:0]];

   typedef struct {
      logic        err;
      logic [15:0] rdata;
   } rsp_t;

   rsp_t        c_q[$];
   rsp_t        d_q[$];
   logic [15:0] ref_mem [int unsigned];
   int          grant_log[$];
   int          n_checks = 0;
   int          n_errors = 0;

   // Reference model state: phase 0 idle, 1 access, 2 response
   int          ph = 0;
   int          m_cnt = 0;
   logic        m_owner_d = 1'b0;
   logic        m_we = 1'b0;
   logic        m_err = 1'b0;
   logic [15:0] m_addr = '0;
   logic [15:0] m_wdata = '0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] ref_read(input logic [15:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
   endfunction

   function automatic logic [15:0] pick_addr();
      case ($urandom_range(0, 11))
         0: return 16'd15;
         1: return 16'd16;
         2: return 16'd2000;
         3: return 16'd2001;
         4: return 16'($urandom);
         5: return 16'd0;
         default: return 16'(16 + $urandom_range(0, 15));
      endcase
   endfunction

   task automatic new_c();
      c_valid = 1'b1; c_we = 1'($urandom_range(0, 1));
      c_addr = pick_addr(); c_wdata = 16'($urandom);
   endtask

   task automatic new_d();
      d_valid = 1'b1; d_we = 1'($urandom_range(0, 1));
      d_addr = pick_addr(); d_wdata = 16'($urandom);
   endtask

   // Predict and compare this cycle's handshakes, strobes and response slot; g = 0 none, 1 C, 2 D
   task automatic cycle_check(output int g);
      logic exp_d, exp_c;
      logic [15:0] a;
      rsp_t r;
      exp_d = (ph == 0) && d_valid && (!c_valid || m_cnt == int'(CB));
      exp_c = (ph == 0) && c_valid && !exp_d;
      chk("c_ready", c_ready, exp_c);
      chk("d_ready", d_ready, exp_d);
      chk("busy", busy, ph != 0);
      chk("mem_read", mem_read, (ph == 1) && !m_we && !m_err);
      chk("mem_write", mem_write, (ph == 1) && m_we && !m_err);
      chk("mem_addr", mem_addr, (ph == 1) ? m_addr : 16'h0);
      chk("mem_d_in", mem_d_in, (ph == 1) ? m_wdata : 16'h0);
      chk("c_rsp_slot", c_rsp_valid, (ph == 2) && !m_owner_d);
      chk("d_rsp_slot", d_rsp_valid, (ph == 2) && m_owner_d);
      g = 0;
      if (exp_c || exp_d) begin
         g         = exp_d ? 2 : 1;
         m_owner_d = exp_d;
         m_we      = exp_d ? d_we : c_we;
         a         = exp_d ? d_addr : c_addr;
         m_addr    = a;
         m_wdata   = exp_d ? d_wdata : c_wdata;
         m_err     = (int'(a) < int'(MLO)) || (int'(a) > int'(MHI));
         r.err     = m_err;
         r.rdata   = 16'h0;
         if (!m_err && m_we) ref_mem[int'(a)] = m_wdata;
         else if (!m_err) r.rdata = ref_read(a);
         if (exp_d) d_q.push_back(r); else c_q.push_back(r);
         m_cnt = (exp_c && d_valid) ? m_cnt + 1 : 0;
         ph = 1;
      end else begin
         ph = (ph == 1) ? 2 : 0;
      end
   endtask

   // Modes: 0 random, 1 both held, 2 C back-to-back only, 3 drop valid on grant
   task automatic run(input int n, input int mode);
      int g;
      int last = -1;
      for (int cyc = 0; cyc < n; cyc++) begin
         @(negedge clk);
         cycle_check(g);
         if (mode == 1 && g != 0) grant_log.push_back(g);
         if (mode == 2 && g == 1) begin
            if (last >= 0) chk("c_ready_period", cyc - last, 3);
            last = cyc;
         end
         @(posedge clk);
         #1;
         case (mode)
            0: begin
               if (g == 1) c_valid = 1'b0;
               if (g == 2) d_valid = 1'b0;
               if (!c_valid) begin
                  c_addr = 16'($urandom); c_we = 1'($urandom_range(0, 1)); c_wdata = 16'($urandom);
                  if ($urandom_range(0, 2) == 0) new_c();
               end else if ($urandom_range(0, 19) == 0) c_valid = 1'b0;
               if (!d_valid) begin
                  d_addr = 16'($urandom); d_we = 1'($urandom_range(0, 1)); d_wdata = 16'($urandom);
                  if ($urandom_range(0, 2) == 0) new_d();
               end else if ($urandom_range(0, 19) == 0) d_valid = 1'b0;
            end
            1: begin
               if (g == 1) new_c();
               if (g == 2) new_d();
            end
            2: if (g == 1) new_c();
            default: begin
               if (g == 1) c_valid = 1'b0;
               if (g == 2) d_valid = 1'b0;
            end
         endcase
      end
   endtask

   // Response monitor: pops the scoreboard whenever a response is presented
   always @(negedge clk) begin
      rsp_t e;
      if (rst_n) begin
         if (c_rsp_valid) begin
            if (c_q.size() == 0) chk("c_rsp_unexpected", 1, 0);
            else begin
               e = c_q.pop_front();
               chk("c_rsp_err", c_rsp_err, e.err);
               chk("c_rdata", c_rdata, e.rdata);
            end
         end else begin
            chk("c_idle_err", c_rsp_err, 0);
            chk("c_idle_rdata", c_rdata, 0);
         end
         if (d_rsp_valid) begin
            if (d_q.size() == 0) chk("d_rsp_unexpected", 1, 0);
            else begin
               e = d_q.pop_front();
               chk("d_rsp_err", d_rsp_err, e.err);
               chk("d_rdata", d_rdata, e.rdata);
            end
         end else begin
            chk("d_idle_err", d_rsp_err, 0);
            chk("d_idle_rdata", d_rdata, 0);
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_outs"}, {c_ready, d_ready, c_rsp_valid, d_rsp_valid, c_rsp_err,
                           d_rsp_err, mem_read, mem_write, busy}, 0);
      chk({tag, "_rdata"}, {c_rdata, d_rdata}, 0);
      chk({tag, "_mem_bus"}, {mem_addr, mem_d_in}, 0);
   endtask

   initial begin
      int g;
      int exp_order [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
      logic [15:0] old_val;
      rst_n = 1'b0;
      c_valid = 0; c_we = 0; c_addr = '0; c_wdata = '0;
      d_valid = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      #12;
      chk_all_zero("reset");
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic write then read-back by C
      c_valid = 1; c_we = 1; c_addr = 16'h0040; c_wdata = 16'hBEEF;
      run(4, 3);
      chk("ref_beef", ref_read(16'h0040), 16'hBEEF);
      c_valid = 1; c_we = 0; c_addr = 16'h0040;
      run(4, 3);

      // Window edges
      c_valid = 1; c_we = 0; c_addr = 16'h000F; run(4, 3);
      c_valid = 1; c_we = 0; c_addr = 16'h0010; run(4, 3);
      d_valid = 1; d_we = 1; d_addr = 16'h07D0; d_wdata = 16'h1357; run(4, 3);
      d_valid = 1; d_we = 1; d_addr = 16'h07D1; d_wdata = 16'h2468; run(4, 3);
      chk("dram_edge_hi", dram[2000], 16'h1357);

      // Both held: CPU burst then one DMA grant
      new_c(); new_d();
      run(30, 1);
      c_valid = 0; d_valid = 0;
      run(3, 3);
      chk("order_len", grant_log.size() >= 10, 1);
      for (int i = 0; i < 10 && i < grant_log.size(); i++) chk("grant_order", grant_log[i], exp_order[i]);

      // C back-to-back with D idle
      new_c();
      run(31, 2);
      c_valid = 0;
      run(3, 3);

      run(2000, 0);
      c_valid = 0; d_valid = 0;
      run(4, 3);

      // Reset while D's write strobe is up
      old_val = ref_read(16'h0050);
      d_valid = 1; d_we = 1; d_addr = 16'h0050; d_wdata = 16'h1234;
      @(negedge clk);
      cycle_check(g);
      chk("rst_test_grant", g, 2);
      @(posedge clk); #1;
      d_valid = 0;
      chk("rst_pre_mem_write", mem_write, 1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      ph = 0; m_cnt = 0; c_q.delete(); d_q.delete();
      ref_mem[32'h50] = old_val;
      #1 rst_n = 1'b1;
      run(6, 3);
      c_valid = 1; c_we = 0; c_addr = 16'h0050;
      run(4, 3);

      chk("c_q_drained", c_q.size(), 0);
      chk("d_q_drained", d_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
